// File: rtl/qr_pkg.sv
// rtl/qr_pkg.sv - shared QR datapath sizing and row-buffer state encoding
package qr_pkg;
    localparam int LENGTH    = 13;
    localparam int ROWS      = 8;
    localparam int COLS      = 4;
    localparam int ROW_W     = COLS * LENGTH;
    localparam int ROW_IDX_W = $clog2(ROWS);
    localparam int COL_IDX_W = $clog2(COLS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;
endpackage

// File: rtl/qr_row_buffer_if.sv
// rtl/qr_row_buffer_if.sv - row input and element output handshake bundle
interface qr_row_buffer_if;
    import qr_pkg::*;

    logic                 in_valid;
    logic [ROW_W-1:0]     in;
    logic                 out_valid;
    logic                 out_ready;
    logic [LENGTH-1:0]    out_data;
    logic [ROW_IDX_W-1:0] out_row;
    logic [COL_IDX_W-1:0] out_col;
    logic                 out_last;

    modport master (
        output in_valid, in, out_ready,
        input  out_valid, out_data, out_row, out_col, out_last
    );

    modport slave (
        input  in_valid, in, out_ready,
        output out_valid, out_data, out_row, out_col, out_last
    );
endinterface

// File: rtl/qr_rowbuf_mem.sv
// rtl/qr_rowbuf_mem.sv - row register file, synchronous write, combinational read
module qr_rowbuf_mem #(
    parameter  int ROWS  = 8,
    parameter  int ROW_W = 52,
    localparam int AW    = $clog2(ROWS)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [ROW_W-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [ROW_W-1:0] rdata_o
);
    logic [ROW_W-1:0] mem_q [ROWS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/qr_row_buffer.sv
// rtl/qr_row_buffer.sv - collects a frame of R rows, then streams it element by element
module qr_row_buffer #(
    parameter int LENGTH = qr_pkg::LENGTH,
    parameter int ROWS   = qr_pkg::ROWS,
    parameter int COLS   = qr_pkg::COLS
) (
    input  logic             clk,
    input  logic             rst_n,
    qr_row_buffer_if.slave   bus,
    output logic             busy,
    output logic             drop_err
);
    import qr_pkg::*;

    localparam int ROW_BITS = COLS * LENGTH;
    localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(ROWS - 1);
    localparam logic [COL_IDX_W-1:0] LAST_COL = COL_IDX_W'(COLS - 1);

    state_e               state_q;
    logic [ROW_IDX_W-1:0] wr_row_q;
    logic [ROW_IDX_W-1:0] rd_row_q;
    logic [COL_IDX_W-1:0] rd_col_q;
    logic                 drop_err_q;

    logic                 draining;
    logic                 at_last;
    logic                 fire;
    logic                 final_hs;
    logic                 wr_en;
    logic [ROW_BITS-1:0]  rd_row_data;

    assign draining = (state_q == ST_DRAIN);
    assign at_last  = (rd_row_q == LAST_ROW) && (rd_col_q == LAST_COL);
    assign fire     = draining && bus.out_ready;
    assign final_hs = fire && at_last;
    // The frame-ending handshake frees the buffer, so a row arriving then starts the next frame.
    assign wr_en    = bus.in_valid && (!draining || final_hs);

    qr_rowbuf_mem #(
        .ROWS  (ROWS),
        .ROW_W (ROW_BITS)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (wr_en),
        .waddr_i (wr_row_q),
        .wdata_i (bus.in),
        .raddr_i (rd_row_q),
        .rdata_o (rd_row_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_row_q   <= '0;
            rd_row_q   <= '0;
            rd_col_q   <= '0;
            drop_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_FILL: begin
                    if (bus.in_valid) begin
                        if (wr_row_q == LAST_ROW) begin
                            state_q  <= ST_DRAIN;
                            wr_row_q <= '0;
                        end else begin
                            state_q  <= ST_FILL;
                            wr_row_q <= wr_row_q + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (bus.in_valid && !final_hs) begin
                        drop_err_q <= 1'b1;
                    end
                    if (final_hs) begin
                        rd_row_q <= '0;
                        rd_col_q <= '0;
                        if (bus.in_valid) begin
                            state_q  <= ST_FILL;
                            wr_row_q <= ROW_IDX_W'(1);
                        end else begin
                            state_q  <= ST_IDLE;
                            wr_row_q <= '0;
                        end
                    end else if (fire) begin
                        if (rd_col_q == LAST_COL) begin
                            rd_col_q <= '0;
                            rd_row_q <= rd_row_q + 1'b1;
                        end else begin
                            rd_col_q <= rd_col_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Data is masked outside DRAIN because the memory is never cleared.
    assign bus.out_valid = draining;
    assign bus.out_row   = rd_row_q;
    assign bus.out_col   = rd_col_q;
    assign bus.out_last  = draining && at_last;
    assign bus.out_data  = draining ? rd_row_data[rd_col_q*LENGTH +: LENGTH] : '0;
    assign busy          = (state_q != ST_IDLE);
    assign drop_err      = drop_err_q;
endmodule
